// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared port-select type and default burst limit for the data-memory arbiter
package dmem_arbiter_pkg;
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;
  localparam int BURST_MAX_DEF = 4;
endpackage

// File: rtl/dmem_arb_grant.sv
// dmem_arb_grant: port-0 priority grant with burst counter that yields to port 1 after BURST_MAX grants
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  logic [3:0] burst_cnt;
  logic       burst_full;
  always_comb begin
    burst_full = burst_cnt == 4'(BURST_MAX);
    gnt1 = reset_n & req1 & (~req0 | burst_full);
    gnt0 = reset_n & req0 & ~gnt1;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) burst_cnt <= '0;
    else if (gnt1 || !req1) burst_cnt <= '0;
    else if (gnt0 && !burst_full) burst_cnt <= burst_cnt + 4'd1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with 1-cycle read responses
// Define DMEM_ARBITER_ALIGN_CHECK_EN to block misaligned accesses and report them on err0/err1.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       read_data
`ifdef DMEM_ARBITER_ALIGN_CHECK_EN
  ,
  output logic              err0,
  output logic              err1
`endif
);
  logic  gnt;
  logic  we;
  logic  bad;
  logic  pending;
  port_t owner;
  dmem_arb_grant #(.BURST_MAX(BURST_MAX)) u_grant (
    .clock  (clock),
    .reset_n(reset_n),
    .req0   (req0),
    .req1   (req1),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );
  always_comb begin
    gnt        = gnt0 | gnt1;
    we         = gnt1 ? we1 : we0;
    address    = gnt1 ? addr1 : gnt0 ? addr0 : '0;
    write_data = gnt1 ? wdata1 : gnt0 ? wdata0 : '0;
    MemRead    = gnt & ~we & ~bad;
    MemWrite   = gnt & we & ~bad;
    rvalid0    = pending & (owner == PORT0);
    rvalid1    = pending & (owner == PORT1);
    rdata0     = rvalid0 ? read_data : '0;
    rdata1     = rvalid1 ? read_data : '0;
  end
`ifdef DMEM_ARBITER_ALIGN_CHECK_EN
  assign bad = gnt & (address[1:0] != 2'b00);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= bad & gnt0;
      err1 <= bad & gnt1;
    end
  end
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending <= 1'b0;
      owner   <= PORT0;
    end else begin
      pending <= MemRead;
      owner   <= gnt1 ? PORT1 : PORT0;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4: max consecutive grants to port 0 while port 1 is requesting (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 32: address width of both requester ports and the memory port.
REQ-003 SHALL have one clock and a synchronous, active-low reset, with ports named per codebase convention: clock, reset_n.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 req0 / req1  in  1  request from port 0 (load/store unit) / port 1 (debug/DMA); held until granted.
REQ-007 we0 / we1  in  1  1 = 32-bit write, 0 = 32-bit read.
REQ-008 addr0 / addr1  in  ADDR_W  byte address of the word.
REQ-009 wdata0 / wdata1  in  32  write data.
REQ-010 gnt0 / gnt1  out  1  combinational grant; request accepted in that cycle.
REQ-011 rvalid0 / rvalid1  out  1  registered read-response strobe.
REQ-012 rdata0 / rdata1  out  32  read data, valid while rvalid is 1; 0 otherwise.
REQ-013 address / write_data  out  ADDR_W / 32  to data memory, muxed from the granted port.
REQ-014 MemRead / MemWrite  out  1  to data memory; at most one is 1 per cycle.
REQ-015 read_data  in  32  from data memory; valid the cycle after the MemRead edge.

Function
REQ-016 SHALL grant at most one port per cycle; grant is a same-cycle combinational decision on req0/req1 and arbiter state.
REQ-017 SHALL give port 0 fixed priority, except when burst_cnt == BURST_MAX and req1 == 1, when port 1 is granted.
REQ-018 burst_cnt SHALL increment on each gnt0 while req1 == 1, saturate at BURST_MAX, and clear on any gnt1 or any cycle with req1 == 0.
REQ-019 On grant, SHALL drive address/write_data from that port and assert MemWrite (we=1) or MemRead (we=0) in the same cycle.
REQ-020 Read latency SHALL be 1 cycle: read granted in cycle N -> rvalid of the same port = 1 in cycle N+1 with rdataX = read_data.
REQ-021 SHALL track the read owner in a 1-bit register plus a pending flag; back-to-back reads from either port are allowed every cycle.
REQ-022 Writes SHALL produce no response; write completes at the grant edge.
REQ-023 With no grant, MemRead = MemWrite = 0, address = 0, write_data = 0.
REQ-024 Simultaneous req0 and req1 with burst_cnt < BURST_MAX SHALL grant port 0 only; port 1 keeps waiting.
REQ-025 A request whose req drops before grant SHALL be ignored without any memory access.

Reset
REQ-026 While reset_n = 0 at a clock edge: gnt0/1 = 0, MemRead = MemWrite = 0, rvalid0/1 = 0, rdata0/1 = 0, burst_cnt = 0, pending = 0.
REQ-027 A read granted in the cycle where reset_n = 0 is sampled SHALL produce no rvalid; grants are suppressed while reset_n = 0.

Configuration
REQ-028 Macro DMEM_ARBITER_ALIGN_CHECK_EN: when defined, adds outputs err0/err1 (1 bit each); a granted access with address[1:0] != 0 SHALL NOT assert MemRead/MemWrite and SHALL pulse errX = 1 in cycle N+1 (rvalidX stays 0).
REQ-029 Without the macro, err0/err1 SHALL not exist and misaligned addresses are forwarded unchanged.

Structure
REQ-030 Shared package SHALL hold the port-select type (PORT0/PORT1) and the BURST_MAX default constant.
REQ-031 A single sub-module, dmem_arb_grant (combinational priority/fairness decision plus burst counter), is the natural split; the datapath mux and response tracking stay in the top.

Verification
REQ-032 Reset: reset_n = 0 for 2 cycles with req0 = 1 -> no gnt0, MemRead = 0, rvalid0 = 0.
REQ-033 Single read: req0, we0 = 0, addr0 = 0x10 -> gnt0 same cycle, MemRead = 1, address = 0x10; next cycle rvalid0 = 1, rdata0 = 0x13121110 (memory init byte[i] = i).
REQ-034 Write then read: port 1 writes 0xDEADBEEF to 0x20, then reads 0x20 -> rvalid1 = 1, rdata1 = 0xDEADBEEF.
REQ-035 Fairness: req0 and req1 held continuously, BURST_MAX = 4 -> grant pattern 0,0,0,0,1 repeating.
REQ-036 Back-to-back reads port0 @0x0, port1 @0x4 in consecutive cycles -> rvalid0 then rvalid1 on consecutive cycles, data 0x03020100 then 0x07060504.
REQ-037 With DMEM_ARBITER_ALIGN_CHECK_EN: req0 read @0x3 -> gnt0 = 1, MemRead = 0; next cycle err0 = 1, rvalid0 = 0.
